// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states, symbol
// codes and element/gap lengths in Morse time units.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MARK = 3'd1,
    EGAP = 3'd2,
    LGAP = 3'd3,
    WGAP = 3'd4
  } state_e;

  localparam logic [1:0] SYM_S   = 2'b00;
  localparam logic [1:0] SYM_O   = 2'b01;
  localparam logic [1:0] SYM_WSP = 2'b10;
  localparam logic [1:0] SYM_RSV = 2'b11;

  localparam int unsigned DOT_U  = 1;
  localparam int unsigned DASH_U = 3;
  localparam int unsigned EGAP_U = 1;
  localparam int unsigned LGAP_U = 2;
  localparam int unsigned WGAP_U = 4;

  localparam int unsigned ELEMS_PER_LETTER = 3;

  // Index of the final unit of a state; the letter selects dot or dash for MARK.
  function automatic logic [1:0] last_unit_idx(input state_e st, input logic [1:0] s);
    logic [1:0] idx;
    idx = '0;
    unique case (st)
      MARK:    idx = (s == SYM_O) ? 2'(DASH_U - 1) : 2'(DOT_U - 1);
      EGAP:    idx = 2'(EGAP_U - 1);
      LGAP:    idx = 2'(LGAP_U - 1);
      WGAP:    idx = 2'(WGAP_U - 1);
      default: idx = '0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Divides the clock into Morse time units; tick marks the last cycle of a unit.
// tick_nxt is the same condition one cycle ahead, used for registered pulses.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_nxt
);

  localparam logic [7:0] LAST = 8'(UNIT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick     = (cnt_q == LAST);
    cnt_d    = (clr || tick) ? '0 : cnt_q + 8'd1;
    tick_nxt = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morse_tx.sv
// Morse serial transmitter for letters S and O plus word spaces, with a
// valid/ready symbol input and back-to-back frame chaining.
module morse_tx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  output logic       sym_ready,
  output logic       out,
  output logic       busy,
  output logic       char_done,
  output logic       err,
  output logic [2:0] current_state
);

  state_e     state_q, state_d;
  logic [1:0] elem_q, elem_d;
  logic [1:0] ucnt_q, ucnt_d;
  logic [1:0] sym_q, sym_d;
  logic       out_q, out_d;
  logic       busy_q, busy_d;
  logic       char_done_q, char_done_d;
  logic       err_q, err_d;

  logic tick, tick_nxt, clr;
  logic unit_end, gap_end, accept;

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .tick    (tick),
    .tick_nxt(tick_nxt)
  );

  always_comb begin
    unit_end  = tick && (ucnt_q == last_unit_idx(state_q, sym_q));
    gap_end   = unit_end && ((state_q == LGAP) || (state_q == WGAP));
    sym_ready = (state_q == IDLE) || gap_end;
    accept    = sym_valid && sym_ready;

    state_d = state_q;
    elem_d  = elem_q;
    sym_d   = sym_q;
    err_d   = 1'b0;

    if (accept) begin
      sym_d = sym;
      err_d = (sym == SYM_RSV);
    end

    unique case (state_q)
      IDLE, LGAP, WGAP: begin
        if (accept) begin
          unique case (sym)
            SYM_S, SYM_O: begin
              state_d = MARK;
              elem_d  = '0;
            end
            SYM_WSP: state_d = WGAP;
            default: state_d = IDLE;
          endcase
        end else if (gap_end) begin
          state_d = IDLE;
        end
      end
      MARK: if (unit_end) state_d = EGAP;
      EGAP: begin
        if (unit_end) begin
          if (elem_q == 2'(ELEMS_PER_LETTER - 1)) begin
            state_d = LGAP;
          end else begin
            state_d = MARK;
            elem_d  = elem_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    clr = (state_d != state_q);
    if (clr || unit_end) ucnt_d = '0;
    else if (tick)       ucnt_d = ucnt_q + 2'd1;
    else                 ucnt_d = ucnt_q;

    // char_done is registered, so predict "next cycle is the final gap cycle".
    char_done_d = ((state_d == LGAP) || (state_d == WGAP)) && tick_nxt &&
                  (ucnt_d == last_unit_idx(state_d, sym_d));
    out_d       = (state_d == MARK);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      ucnt_q      <= '0;
      sym_q       <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      char_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      ucnt_q      <= ucnt_d;
      sym_q       <= sym_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      char_done_q <= char_done_d;
      err_q       <= err_d;
    end
  end

  assign out           = out_q;
  assign busy          = busy_q;
  assign char_done     = char_done_q;
  assign err           = err_q;
  assign current_state = state_q;

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 1: clock cycles per Morse time unit, legal range 1..255.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: reset, synchronous and active-high.
REQ-004 Port sym_valid SHALL be an input, 1 bit: a symbol is offered on sym.
REQ-005 Port sym SHALL be an input, 2 bits: 00=S, 01=O, 10=word space, 11=reserved.
REQ-006 Port sym_ready SHALL be an output, 1 bit: the block accepts sym this cycle.
REQ-007 Port out SHALL be an output, 1 bit: the registered Morse serial line, 1=mark, 0=space.
REQ-008 Port busy SHALL be an output, 1 bit: high whenever the state is not IDLE.
REQ-009 Port char_done SHALL be an output, 1 bit: a one-cycle pulse on the final cycle of a letter gap or word gap.
REQ-010 Port err SHALL be an output, 1 bit: a one-cycle pulse in the cycle after a reserved symbol is accepted.
REQ-011 Port current_state SHALL be an output, 3 bits: the FSM state encoding, for debug.

Function
REQ-012 Line format SHALL be:
- dot = 1 unit high; dash = 3 units high;
- each element is followed by a 1-unit low gap;
- a letter appends 2 further low units (3-unit letter gap);
- a word space is 4 low units, giving 7 units total after a letter.
REQ-013 Letter S SHALL be three dots and letter O SHALL be three dashes.
REQ-014 At UNIT_CYCLES=1, out SHALL be 10101000 (8 cycles) for S, 11101110111000 (14 cycles) for O, and 0000 for a word space.
REQ-015 A symbol SHALL be accepted exactly on a clock edge where sym_valid and sym_ready are both high.
REQ-016 sym SHALL be captured at acceptance, and later changes on sym or sym_valid SHALL be ignored until the next acceptance.
REQ-017 sym_ready SHALL be high in IDLE and during the last cycle of an LGAP or WGAP, and low otherwise.
REQ-018 On acceptance of S or O, out SHALL be 1 starting in the next cycle (latency 1 cycle).
REQ-019 Back-to-back symbols SHALL produce no idle cycles between frames.
REQ-020 The FSM SHALL have states IDLE, MARK, EGAP, LGAP and WGAP.
REQ-021 FSM transitions SHALL be:
- IDLE -> MARK on S/O accept, or -> WGAP on word-space accept;
- MARK -> EGAP after 1 or 3 units;
- EGAP -> MARK if elements remain, else -> LGAP;
- LGAP (2 units) and WGAP (4 units) -> MARK/WGAP on same-cycle accept, else -> IDLE.
REQ-022 On accepting a reserved code, the block SHALL emit no line activity, stay in IDLE, and pulse err the following cycle.
REQ-023 The element counter SHALL be 2 bits, counting 3 elements.
REQ-024 The unit counter SHALL be 8 bits and SHALL wrap to 0 when a unit completes (count = UNIT_CYCLES-1).
REQ-025 out SHALL be high only in MARK.

Reset
REQ-026 When rst is high at a clock edge, the block SHALL set state to IDLE, out to 0, busy to 0, char_done to 0, err to 0, all counters to 0, and the captured symbol to 00.
REQ-027 Reset SHALL take priority over acceptance, and reset during a frame SHALL abort the frame immediately with no char_done.
REQ-028 sym_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-029 Package morse_pkg SHALL hold:
- the state enum;
- the symbol codes (SYM_S, SYM_O, SYM_WSP, SYM_RSV);
- the unit lengths DOT_U=1, DASH_U=3, EGAP_U=1, LGAP_U=2 and WGAP_U=4.
REQ-030 Sub-module morse_unit_timer SHALL generate the unit-end tick from UNIT_CYCLES, with a synchronous clear on state change.

Verification
REQ-031 Scenario 1: with UNIT_CYCLES=1, reset then S accepted once -> out = 10101000, char_done on cycle 8, busy low on cycle 9.
REQ-032 Scenario 2: S, word space, O, word space, S held valid continuously -> one contiguous stream, with no bubbles at frame boundaries.
REQ-033 Scenario 3: with UNIT_CYCLES=3, O accepted -> each out bit stretched ×3, for 42 cycles total.
REQ-034 Scenario 4: sym=11 accepted -> out stays 0, err pulses 1 cycle, sym_ready stays 1.
REQ-035 Scenario 5: rst asserted in the middle of the second dash of O -> out=0 the next cycle, state IDLE, no char_done, and sym_ready=1 after release.
REQ-036 Scenario 6: sym changed mid-frame while sym_valid stays high -> the current frame is unchanged, and the new value is accepted only in the last LGAP cycle.
